// File: rtl/iter_addsub.sv
// Multi-cycle add/subtract unit: adds CHUNK bits per clock with a registered ripple carry,
// valid/ready handshakes on both sides and carry/overflow/zero flags on the result.
module iter_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_y,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_zero
);

    localparam int unsigned NSTEP  = WIDTH / CHUNK;
    localparam int unsigned STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_carry;
    logic [STEP_W-1:0] r_step;
    logic [WIDTH-1:0]  r_y;
    logic              r_cout;
    logic              r_ovf;
    logic              r_zero;

    logic [CHUNK-1:0]  w_a_chunk;
    logic [CHUNK-1:0]  w_b_chunk;
    logic [CHUNK:0]    w_sum;
    logic [WIDTH-1:0]  w_y_upd;
    logic              w_last;
    logic              w_ovf;

    // One chunk of the ripple add; r_b already holds the inverted operand for subtract.
    always_comb begin
        w_a_chunk = r_a[r_step*CHUNK +: CHUNK];
        w_b_chunk = r_b[r_step*CHUNK +: CHUNK];
        w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
        w_y_upd   = r_y;
        w_y_upd[r_step*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
        w_last    = (r_step == LAST_STEP);
        w_ovf     = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_y_upd[WIDTH-1] != r_a[WIDTH-1]);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_step  <= '0;
            r_y     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_a     <= i_a;
                        r_b     <= i_sub ? ~i_b : i_b;
                        r_carry <= i_sub ? 1'b1 : i_cin;
                        r_step  <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_y     <= w_y_upd;
                    r_carry <= w_sum[CHUNK];
                    if (w_last) begin
                        r_cout  <= w_sum[CHUNK];
                        r_ovf   <= w_ovf;
                        r_zero  <= (w_y_upd == '0);
                        r_state <= S_DONE;
                    end else begin
                        r_step <= r_step + 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready  = (r_state == S_IDLE);
    assign o_out_valid = (r_state == S_DONE);
    assign o_y         = r_y;
    assign o_cout      = r_cout;
    assign o_ovf       = r_ovf;
    assign o_zero      = r_zero;

endmodule

// File: tb/tb_iter_addsub.sv
// Directed bench for iter_addsub: flag/edge vectors, backpressure, mid-run reset and a
// decimal-operand sweep over several WIDTH/CHUNK configurations.
module tb_iter_addsub;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Main instance, WIDTH=32 CHUNK=8
    logic        m_valid = 1'b0, m_ordy = 1'b0, m_cin = 1'b0, m_sub = 1'b0;
    logic [31:0] m_a = '0, m_b = '0;
    logic        m_irdy, m_ovld, m_cout, m_ovf, m_zero;
    logic [31:0] m_y;

    iter_addsub #(.WIDTH(32), .CHUNK(8)) u_main (
        .i_clk(clk), .i_reset(rst), .i_in_valid(m_valid), .o_in_ready(m_irdy),
        .i_a(m_a), .i_b(m_b), .i_cin(m_cin), .i_sub(m_sub), .o_out_valid(m_ovld),
        .i_out_ready(m_ordy), .o_y(m_y), .o_cout(m_cout), .o_ovf(m_ovf), .o_zero(m_zero)
    );

    // Sweep instances: 0:C1 1:C4 2:C32 (WIDTH=32), 3: WIDTH=64 C16
    logic        sw_valid[4], sw_ordy[4], sw_irdy[4], sw_ovld[4];
    logic        sw_cout[4], sw_ovf[4], sw_zero[4];
    logic [31:0] sw_y32[3];
    logic [63:0] sw_y64;
    logic [63:0] sw_a = '0, sw_b = '0;
    logic        sw_cin = 1'b0;
    logic        sw_sub = 1'b0;

    iter_addsub #(.WIDTH(32), .CHUNK(1)) u_c1 (
        .i_clk(clk), .i_reset(rst), .i_in_valid(sw_valid[0]), .o_in_ready(sw_irdy[0]),
        .i_a(sw_a[31:0]), .i_b(sw_b[31:0]), .i_cin(sw_cin), .i_sub(sw_sub),
        .o_out_valid(sw_ovld[0]), .i_out_ready(sw_ordy[0]), .o_y(sw_y32[0]),
        .o_cout(sw_cout[0]), .o_ovf(sw_ovf[0]), .o_zero(sw_zero[0])
    );
    iter_addsub #(.WIDTH(32), .CHUNK(4)) u_c4 (
        .i_clk(clk), .i_reset(rst), .i_in_valid(sw_valid[1]), .o_in_ready(sw_irdy[1]),
        .i_a(sw_a[31:0]), .i_b(sw_b[31:0]), .i_cin(sw_cin), .i_sub(sw_sub),
        .o_out_valid(sw_ovld[1]), .i_out_ready(sw_ordy[1]), .o_y(sw_y32[1]),
        .o_cout(sw_cout[1]), .o_ovf(sw_ovf[1]), .o_zero(sw_zero[1])
    );
    iter_addsub #(.WIDTH(32), .CHUNK(32)) u_c32 (
        .i_clk(clk), .i_reset(rst), .i_in_valid(sw_valid[2]), .o_in_ready(sw_irdy[2]),
        .i_a(sw_a[31:0]), .i_b(sw_b[31:0]), .i_cin(sw_cin), .i_sub(sw_sub),
        .o_out_valid(sw_ovld[2]), .i_out_ready(sw_ordy[2]), .o_y(sw_y32[2]),
        .o_cout(sw_cout[2]), .o_ovf(sw_ovf[2]), .o_zero(sw_zero[2])
    );
    iter_addsub #(.WIDTH(64), .CHUNK(16)) u_w64 (
        .i_clk(clk), .i_reset(rst), .i_in_valid(sw_valid[3]), .o_in_ready(sw_irdy[3]),
        .i_a(sw_a), .i_b(sw_b), .i_cin(sw_cin), .i_sub(sw_sub),
        .o_out_valid(sw_ovld[3]), .i_out_ready(sw_ordy[3]), .o_y(sw_y64),
        .o_cout(sw_cout[3]), .o_ovf(sw_ovf[3]), .o_zero(sw_zero[3])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One op on the main instance; operands are scrambled after accept to prove latching.
    task automatic run_main(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic sub, input logic [31:0] ey,
                            input logic ec, input logic eo, input logic ez);
        int lat;
        chk({tag, "_irdy"}, m_irdy, 1);
        m_a = a; m_b = b; m_cin = cin; m_sub = sub; m_valid = 1'b1;
        step();
        m_valid = 1'b0; m_a = $urandom; m_b = $urandom; m_cin = ~cin; m_sub = ~sub;
        lat = 0;
        while (!m_ovld && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_y"}, m_y, ey);
        chk({tag, "_cout"}, m_cout, ec);
        chk({tag, "_ovf"}, m_ovf, eo);
        chk({tag, "_zero"}, m_zero, ez);
        m_ordy = 1'b1;
        step();
        m_ordy = 1'b0;
        chk({tag, "_idle"}, {m_irdy, m_ovld}, 2'b10);
        chk({tag, "_hold"}, m_y, ey);
    endtask

    task automatic sweep_op(input int k, input int nstep, input logic [63:0] a,
                            input logic [63:0] b, input logic c);
        int          lat;
        logic [64:0] exp, obs;
        sw_a = a; sw_b = b; sw_cin = c; sw_valid[k] = 1'b1;
        step();
        sw_valid[k] = 1'b0;
        lat = 0;
        while (!sw_ovld[k] && lat < nstep + 10) begin
            step();
            lat++;
        end
        exp = {1'b0, a} + {1'b0, b} + {64'b0, c};
        if (k == 3) obs = {sw_cout[3], sw_y64};
        else        obs = {32'b0, sw_cout[k], sw_y32[k]};
        chk($sformatf("sw%0d_lat", k), lat, nstep);
        chk($sformatf("sw%0d_sum_%0d_%0d_%0d", k, a, b, c), obs, exp);
        sw_ordy[k] = 1'b1;
        step();
        sw_ordy[k] = 1'b0;
    endtask

    initial begin
        int          lat;
        logic        stale;
        logic [63:0] p10[20];
        int          nsteps[4];

        for (int k = 0; k < 4; k++) begin
            sw_valid[k] = 1'b0;
            sw_ordy[k]  = 1'b0;
        end
        p10[0] = 64'd1;
        for (int n = 1; n < 20; n++) p10[n] = p10[n-1] * 64'd10;
        nsteps[0] = 32; nsteps[1] = 8; nsteps[2] = 1; nsteps[3] = 4;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("reset_state", {m_irdy, m_ovld, m_cout, m_ovf, m_zero}, 5'b10000);
        chk("reset_y", m_y, 0);

        run_main("max_add",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1, 0, 0);
        run_main("add_ovf",  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 0, 1, 0);
        run_main("add_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1, 0, 1);
        run_main("sub_neg",  32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 0, 0, 0);
        run_main("sub_ovf",  32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1, 1, 0);
        run_main("sub_eq",   32'h00001234, 32'h00001234, 1'b0, 1'b1, 32'h00000000, 1, 0, 1);

        // Backpressure: result held in DONE, in_valid pulses ignored
        m_a = 32'h11111111; m_b = 32'h22222222; m_cin = 1'b0; m_sub = 1'b0; m_valid = 1'b1;
        step();
        m_valid = 1'b0;
        lat = 0;
        while (!m_ovld && lat < 40) begin
            step();
            lat++;
        end
        chk("bp_lat", lat, 4);
        for (int i = 0; i < 5; i++) begin
            m_valid = i[0];
            m_a = 32'hDEAD0000 + i;
            step();
            chk($sformatf("bp_hold%0d", i), {m_ovld, m_irdy, m_cout, m_ovf, m_zero}, 5'b10000);
            chk($sformatf("bp_y%0d", i), m_y, 32'h33333333);
        end
        m_valid = 1'b0;
        m_ordy = 1'b1;
        step();
        m_ordy = 1'b0;
        chk("bp_release", {m_irdy, m_ovld}, 2'b10);
        run_main("bp_next", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 0, 0, 0);

        // Reset in the second RUN cycle
        m_a = 32'hAAAAAAAA; m_b = 32'h55555555; m_cin = 1'b1; m_sub = 1'b0; m_valid = 1'b1;
        step();
        m_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_run_state", {m_irdy, m_ovld, m_cout, m_ovf, m_zero}, 5'b10000);
        chk("rst_run_y", m_y, 0);
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            stale = stale | m_ovld;
        end
        chk("rst_no_stale", stale, 0);
        run_main("rst_next", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 0, 0, 0);

        // Parameter sweep: a=10^i, b=9*10^j
        for (int k = 0; k < 4; k++) begin
            int imax;
            int jmax;
            imax = (k == 3) ? 19 : 9;
            jmax = (k == 3) ? 18 : 8;
            for (int i = 0; i <= imax; i++) begin
                for (int j = 0; j <= jmax; j++) begin
                    for (int c = 0; c < 2; c++) begin
                        sweep_op(k, nsteps[k], p10[i], p10[j] * 64'd9, c[0]);
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
